// File: rtl/seg7_scan_counter.sv
// Multi-digit BCD up/down counter multiplexed onto a shared 7-segment bus.
// A prescaler paces count steps; a separate divider paces the one-hot digit scan.
module seg7_scan_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned SCAN_DIV = 100,
    parameter bit          LZ_BLANK = 1'b1,
    parameter bit          SEG_INV  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  up_dn,
    input  logic                  hold,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap
);

    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]    SEG_OFF    = SEG_INV ? 7'h7F : 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrap_q, wrap_d;
    logic [SW-1:0] div_q, div_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [DIGITS-1:0] dig_q, dig_d;

    logic          run;
    logic          tick;
    logic [CW-1:0] step_val;
    logic          step_roll;
    logic [CW-1:0] load_clamped;
    logic [3:0]    nib;
    logic          carry;
    logic [DIGITS-1:0] blank;
    logic          upper_zero;
    logic [3:0]    cur_nib;
    logic          cur_blank;
    logic [6:0]    seg_logic;

    // Prescaler: free-runs while enabled and not held; only clr resets it.
    always_comb begin
        run     = ena & ~hold;
        tick    = run & (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // BCD +/-1 with ripple carry/borrow; step_roll means every digit rolled over.
    always_comb begin
        step_val = count_q;
        carry    = 1'b1;
        nib      = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = count_q[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (nib == 4'd9) begin
                        nib = 4'd0;
                    end else begin
                        nib   = nib + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        nib = 4'd9;
                    end else begin
                        nib   = nib - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            step_val[4*i +: 4] = nib;
        end
        step_roll = carry;
    end

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (tick) begin
            count_d = step_val;
            wrap_d  = step_roll;
        end
    end

    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (ena) begin
            if (div_q == SCAN_LAST) begin
                div_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                div_d = div_q + SW'(1);
            end
        end
    end

    // A digit above 0 is blank when it and every digit above it are zero.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (count_q[4*i +: 4] == 4'd0);
            blank[i]   = LZ_BLANK & (i != 0) & upper_zero;
        end
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = count_q[4*i +: 4];
                cur_blank = blank[i];
            end
        end
    end

    always_comb begin
        seg_logic = cur_blank ? 7'h00 : seg_decode(cur_nib);
        if (ena) begin
            dig_d = DIGITS'(1) << idx_q;
            seg_d = seg_logic ^ {7{SEG_INV}};
            dp_d  = (hold & (idx_q == '0)) ^ SEG_INV;
        end else begin
            dig_d = '0;
            seg_d = SEG_OFF;
            dp_d  = SEG_INV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= SEG_INV;
            dig_q   <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign dig_sel   = dig_q;
    assign count_bcd = count_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Randomised self-checking bench for seg7_scan_counter against an integer-valued
// reference model (count held as a plain number, digits derived by arithmetic).
module tb_seg7_scan_counter;

    localparam int D    = 4;
    localparam int TD   = 4;
    localparam int SD   = 2;
    localparam int MAXV = 9999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, up_dn, hold, clr, load;
    logic [15:0] load_val;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_sel;
    logic [15:0] count_bcd;
    logic        wrap;

    seg7_scan_counter #(
        .DIGITS  (D),
        .TICK_DIV(TD),
        .SCAN_DIV(SD),
        .LZ_BLANK(1'b1),
        .SEG_INV (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .up_dn    (up_dn),
        .hold     (hold),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .seg      (seg),
        .dp       (dp),
        .dig_sel  (dig_sel),
        .count_bcd(count_bcd),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_val, m_presc, m_div, m_idx;
    logic [6:0]  e_seg;
    logic        e_dp, e_wrap;
    logic [3:0]  e_dig;
    logic [28:0] exp_v;
    logic [28:0] obs;

    assign obs = {count_bcd, seg, dp, dig_sel, wrap};

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [15:0] b);
        int v = 0;
        int n;
        for (int i = 0; i < D; i++) begin
            n = int'(b[4*i +: 4]);
            if (n > 9) n = 9;
            v = v + n * pow10(i);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_val = 0; m_presc = 0; m_div = 0; m_idx = 0;
        e_seg = '0; e_dp = 1'b0; e_wrap = 1'b0; e_dig = '0;
        exp_v = '0;
    endtask

    // Advance the model by one clock using the inputs the DUT will see at the edge.
    task automatic model_step();
        int  n;
        bit  t;
        if (ena) begin
            e_dig = 4'(1 << m_idx);
            n     = (m_val / pow10(m_idx)) % 10;
            e_seg = (m_idx > 0 && m_val < pow10(m_idx)) ? 7'h00 : seg_of(n);
            e_dp  = hold && (m_idx == 0);
        end else begin
            e_dig = '0; e_seg = '0; e_dp = 1'b0;
        end
        e_wrap = 1'b0;
        t = ena && !hold && (m_presc == TD - 1);
        if (ena && !hold) m_presc = (m_presc + 1) % TD;
        if (clr) begin
            m_val = 0; m_presc = 0;
        end else if (load) begin
            m_val = from_bcd_clamped(load_val);
        end else if (t) begin
            if (up_dn) begin
                if (m_val == MAXV) begin m_val = 0; e_wrap = 1'b1; end
                else m_val = m_val + 1;
            end else begin
                if (m_val == 0) begin m_val = MAXV; e_wrap = 1'b1; end
                else m_val = m_val - 1;
            end
        end
        if (ena) begin
            m_div = (m_div + 1) % SD;
            if (m_div == 0) m_idx = (m_idx + 1) % D;
        end
        exp_v = {to_bcd(m_val), e_seg, e_dp, e_dig, e_wrap};
    endtask

    task automatic tick_clk();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 0; up_dn = 1; hold = 0; clr = 0; load = 0; load_val = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 29'd0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", obs); end
        rst_n = 1'b1;
        model_reset();
        n_checks++;
        if (obs !== 29'd0) begin n_fail++; $display("FAIL reset_release: got %h want 0", obs); end
    endtask

    task automatic test_count_up();
        logic [6:0] want;
        ena = 1; up_dn = 1;
        for (int c = 0; c < 40; c++) begin
            tick_clk();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL count_up c%0d: got %h want %h", c, obs, exp_v); end
        end
        n_checks++;
        if (count_bcd !== 16'h0010) begin n_fail++; $display("FAIL count_up_40: got %h want 0010", count_bcd); end
        hold = 1;
        for (int c = 0; c < 8; c++) begin
            tick_clk();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL count_up_disp c%0d: got %h want %h", c, obs, exp_v); end
            want = (dig_sel == 4'b0001) ? 7'h3F : (dig_sel == 4'b0010) ? 7'h06 : 7'h00;
            n_checks++;
            if (seg !== want) begin n_fail++; $display("FAIL count_up_seg sel=%b: got %h want %h", dig_sel, seg, want); end
        end
        hold = 0;
    endtask

    task automatic test_wrap_up();
        int wraps = 0;
        bit found = 0;
        up_dn = 1; load_val = 16'h9998; load = 1;
        tick_clk();
        load = 0;
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_up_load: got %h want %h", obs, exp_v); end
        for (int c = 0; c < 20 && !found; c++) begin
            tick_clk();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_up c%0d: got %h want %h", c, obs, exp_v); end
            if (wrap === 1'b1) wraps++;
            if (count_bcd === 16'h0000) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL wrap_up_timeout: got %h want 0000", count_bcd); end
        n_checks++;
        if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_up_pulse: got %b want 1", wrap); end
        for (int c = 0; c < 3; c++) begin
            tick_clk();
            if (wrap === 1'b1) wraps++;
        end
        n_checks++;
        if (wraps != 1) begin n_fail++; $display("FAIL wrap_up_width: got %0d want 1", wraps); end
    endtask

    task automatic test_wrap_down();
        bit found = 0;
        clr = 1;
        tick_clk();
        clr = 0; up_dn = 0;
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_dn_clr: got %h want %h", obs, exp_v); end
        for (int c = 0; c < 10 && !found; c++) begin
            tick_clk();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_dn c%0d: got %h want %h", c, obs, exp_v); end
            if (count_bcd !== 16'h0000) found = 1;
        end
        n_checks++;
        if (count_bcd !== 16'h9999) begin n_fail++; $display("FAIL wrap_dn_val: got %h want 9999", count_bcd); end
        n_checks++;
        if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_dn_pulse: got %b want 1", wrap); end
        hold = 1;
        for (int c = 0; c < 8; c++) begin
            tick_clk();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_dn_hold c%0d: got %h want %h", c, obs, exp_v); end
            if (dig_sel != 4'b0000) begin
                n_checks++;
                if (seg !== 7'h6F) begin n_fail++; $display("FAIL wrap_dn_seg sel=%b: got %h want 6f", dig_sel, seg); end
            end
        end
        hold = 0;
    endtask

    task automatic test_load_clamp();
        ena = 1; hold = 0; up_dn = 1;
        for (int c = 0; c < 10 && m_presc != TD - 1; c++) tick_clk();
        // This cycle also carries a tick; the load must take priority.
        load_val = 16'hF3A1; load = 1;
        tick_clk();
        load = 0;
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL load_model: got %h want %h", obs, exp_v); end
        n_checks++;
        if (count_bcd !== 16'h9391) begin n_fail++; $display("FAIL load_clamp: got %h want 9391", count_bcd); end
        tick_clk();
        n_checks++;
        if (count_bcd !== 16'h9391) begin n_fail++; $display("FAIL load_wins: got %h want 9391", count_bcd); end
    endtask

    task automatic test_hold();
        logic [15:0] saved;
        int remaining, cycles;
        bit moved = 0;
        tick_clk();
        hold = 1;
        saved = count_bcd;
        for (int c = 0; c < 20; c++) begin
            tick_clk();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL hold c%0d: got %h want %h", c, obs, exp_v); end
            n_checks++;
            if (count_bcd !== saved) begin n_fail++; $display("FAIL hold_count: got %h want %h", count_bcd, saved); end
            n_checks++;
            if (dp !== (dig_sel == 4'b0001)) begin n_fail++; $display("FAIL hold_dp sel=%b: got %b want %b", dig_sel, dp, dig_sel == 4'b0001); end
        end
        hold = 0;
        remaining = TD - 1 - m_presc;
        cycles = 0;
        for (int c = 0; c < 10 && !moved; c++) begin
            tick_clk();
            cycles++;
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL hold_resume c%0d: got %h want %h", c, obs, exp_v); end
            if (count_bcd !== saved) moved = 1;
        end
        n_checks++;
        if (!moved || cycles != remaining + 1) begin
            n_fail++; $display("FAIL hold_latency: got %0d want %0d", cycles, remaining + 1);
        end
    endtask

    task automatic test_ena();
        logic [15:0] saved;
        int held_idx;
        ena = 1; up_dn = 1;
        repeat (3) tick_clk();
        ena = 0;
        saved = count_bcd;
        tick_clk();
        n_checks++;
        if (dig_sel !== 4'b0000 || seg !== 7'h00 || dp !== 1'b0) begin
            n_fail++; $display("FAIL ena_off_disp: got sel=%b seg=%h dp=%b want 0/00/0", dig_sel, seg, dp);
        end
        for (int c = 0; c < 6; c++) begin
            tick_clk();
            n_checks++;
            if (count_bcd !== saved) begin n_fail++; $display("FAIL ena_frozen: got %h want %h", count_bcd, saved); end
        end
        load_val = 16'h1234; load = 1;
        tick_clk();
        load = 0;
        n_checks++;
        if (count_bcd !== 16'h1234) begin n_fail++; $display("FAIL ena_off_load: got %h want 1234", count_bcd); end
        held_idx = m_idx;
        ena = 1;
        tick_clk();
        n_checks++;
        if (dig_sel !== 4'(1 << held_idx)) begin
            n_fail++; $display("FAIL ena_resume: got %b want %b", dig_sel, 4'(1 << held_idx));
        end
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ena_model: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ena      = ($urandom_range(0, 9) != 0);
            hold     = ($urandom_range(0, 4) == 0);
            up_dn    = 1'($urandom_range(0, 1));
            clr      = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = 16'($urandom);
            tick_clk();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL random c%0d: got %h want %h", c, obs, exp_v); end
        end
        clr = 0; load = 0; hold = 0; ena = 1;
    endtask

    task automatic test_async_reset();
        up_dn = 1;
        load_val = 16'h0987; load = 1;
        tick_clk();
        load = 0;
        repeat (5) tick_clk();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 29'd0) begin n_fail++; $display("FAIL async_reset: got %h want 0", obs); end
        #2 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 20; c++) begin
            tick_clk();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL post_reset c%0d: got %h want %h", c, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_clamp();
        test_hold();
        test_ena();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
